// File: rtl/ts_speed.sv
// rtl/ts_speed.sv - per-channel transport-stream packet-rate meter with byte-serial report
module ts_speed #(
  parameter int CH_BITS = 4,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ts_din,
  input  logic        ts_din_en,
  input  logic        rate_con_start,
  input  logic        rate_con_end,
  output logic [7:0]  rate_dout,
  output logic        rate_dout_en
);

  localparam int NCH   = 1 << CH_BITS;
  localparam int IDX_W = CH_BITS + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DUMP    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  logic [1:0]         state;
  logic               en_d;
  logic               sop;
  logic [CH_BITS-1:0] sop_ch;
  logic [IDX_W-1:0]   byte_idx;
  logic [CH_BITS-1:0] dump_ch;
  logic [15:0]        dump_word;
  logic [CNT_W-1:0]   cnt [NCH];
  logic               unused_din_bits;

  // Only the channel field of the first word matters; the payload is ignored.
  assign unused_din_bits = ^ts_din[31:CH_BITS];

  assign sop     = ts_din_en & ~en_d;
  assign sop_ch  = ts_din[CH_BITS-1:0];
  assign dump_ch = byte_idx[IDX_W-1:1];

  // Counter being reported, zero-extended to the 16-bit report field.
  always_comb begin
    dump_word = 16'(cnt[dump_ch]);
  end

  // Delayed enable for rising-edge (start-of-packet) detection, free-running.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_d <= 1'b0;
    end else begin
      en_d <= ts_din_en;
    end
  end

  // Window control: start (re)opens, end in MEASURE hands over to the dump.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      byte_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rate_con_start) state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (!rate_con_start && rate_con_end) begin
            state    <= ST_DUMP;
            byte_idx <= '0;
          end
        end
        ST_DUMP: begin
          byte_idx <= byte_idx + IDX_W'(1);
          if (byte_idx == IDX_LAST) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-channel saturating packet counters; start clears, and wins over a same-cycle sop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if ((state == ST_IDLE || state == ST_MEASURE) && rate_con_start) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if (state == ST_MEASURE && sop && cnt[sop_ch] != CNT_MAX) begin
      cnt[sop_ch] <= cnt[sop_ch] + CNT_W'(1);
    end
  end

  // Registered report bytes: MSB then LSB of each channel, in channel order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rate_dout    <= 8'd0;
      rate_dout_en <= 1'b0;
    end else if (state == ST_DUMP) begin
      rate_dout    <= byte_idx[0] ? dump_word[7:0] : dump_word[15:8];
      rate_dout_en <= 1'b1;
    end else begin
      rate_dout_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ts_speed.sv
// tb/tb_ts_speed.sv - randomized self-checking bench for ts_speed
module tb_ts_speed;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ts_din = '0;
  logic        ts_din_en = 1'b0;
  logic        rate_con_start = 1'b0;
  logic        rate_con_end = 1'b0;
  logic [7:0]  rate_dout, rate_dout2;
  logic        rate_dout_en, rate_dout_en2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model: plain packet tallies while the window is open
  int mcnt [16];
  bit mmeas = 0;

  logic [7:0] got[$];
  int         got_cyc[$];
  logic [7:0] got2[$];

  ts_speed #(.CH_BITS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ts_din(ts_din), .ts_din_en(ts_din_en),
    .rate_con_start(rate_con_start), .rate_con_end(rate_con_end),
    .rate_dout(rate_dout), .rate_dout_en(rate_dout_en)
  );

  // narrow-counter instance so saturation is reachable in a short run
  ts_speed #(.CH_BITS(4), .CNT_W(8)) dut_sat (
    .clk(clk), .rst(rst), .ts_din(ts_din), .ts_din_en(ts_din_en),
    .rate_con_start(rate_con_start), .rate_con_end(rate_con_end),
    .rate_dout(rate_dout2), .rate_dout_en(rate_dout_en2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rate_dout_en) begin
      got.push_back(rate_dout);
      got_cyc.push_back(cyc);
    end
    if (rate_dout_en2) got2.push_back(rate_dout2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mcnt[i] = 0;
  endtask

  task automatic send_burst(input int ch, input int len);
    logic [31:0] r;
    for (int i = 0; i < len; i++) begin
      r = $urandom();
      ts_din_en = 1'b1;
      ts_din = (i == 0) ? {r[31:4], 4'(ch)} : r;
      tick();
    end
    ts_din_en = 1'b0;
    tick();
    if (mmeas) mcnt[ch]++;
  endtask

  task automatic pulse_start();
    rate_con_start = 1'b1;
    tick();
    rate_con_start = 1'b0;
    model_clear();
    mmeas = 1;
  endtask

  task automatic pulse_end(output int end_cyc);
    got.delete(); got_cyc.delete(); got2.delete();
    rate_con_end = 1'b1;
    tick();
    end_cyc = cyc;
    rate_con_end = 1'b0;
    mmeas = 0;
  endtask

  task automatic check_report(input string name, input int end_cyc);
    bit timing_ok;
    logic [15:0] w, exp;
    repeat (40) tick();
    checks++;
    if (got.size() != 32 || got2.size() != 32) begin
      errors++;
      $display("FAIL %s byte_count: got %0d/%0d, expected 32/32", name, got.size(), got2.size());
      return;
    end
    timing_ok = 1;
    for (int i = 0; i < 32; i++) if (got_cyc[i] != end_cyc + 1 + i) timing_ok = 0;
    checks++;
    if (!timing_ok) begin
      errors++;
      $display("FAIL %s timing: first byte at edge %0d, last at %0d, expected %0d..%0d",
               name, got_cyc[0], got_cyc[31], end_cyc + 1, end_cyc + 32);
    end
    for (int c = 0; c < 16; c++) begin
      w = {got[2*c], got[2*c+1]};
      exp = 16'((mcnt[c] > 65535) ? 65535 : mcnt[c]);
      checks++;
      if (w !== exp) begin
        errors++;
        $display("FAIL %s ch%0d: got 0x%04h, expected 0x%04h", name, c, w, exp);
      end
      w = {got2[2*c], got2[2*c+1]};
      exp = 16'((mcnt[c] > 255) ? 255 : mcnt[c]);
      checks++;
      if (w !== exp) begin
        errors++;
        $display("FAIL %s sat_ch%0d: got 0x%04h, expected 0x%04h", name, c, w, exp);
      end
    end
  endtask

  task automatic test_reset();
    int e;
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (rate_dout !== 8'd0 || rate_dout_en !== 1'b0 || rate_dout_en2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: dout=%h en=%b en2=%b, expected 00 0 0", rate_dout, rate_dout_en, rate_dout_en2);
    end
    rst = 1'b1;
    model_clear();
    mmeas = 0;
    got.delete();
    repeat (20) tick();
    checks++;
    if (got.size() != 0 || rate_dout !== 8'd0) begin
      errors++;
      $display("FAIL idle_quiet: bytes=%0d dout=%h, expected 0 bytes dout 00", got.size(), rate_dout);
    end
    for (int i = 0; i < 3; i++) send_burst(5, 48);
    pulse_start();
    pulse_end(e);
    check_report("idle_bursts", e);
  endtask

  task automatic test_single_channel();
    int e;
    pulse_start();
    for (int i = 0; i < 10; i++) send_burst(3, 48);
    pulse_end(e);
    check_report("ch3_x10", e);
    checks++;
    if (got.size() != 32 || got[6] !== 8'h00 || got[7] !== 8'h0A) begin
      errors++;
      $display("FAIL ch3_bytes: size=%0d, expected byte6=00 byte7=0a", got.size());
    end
  endtask

  task automatic test_random();
    int e, sum;
    pulse_start();
    for (int i = 0; i < 299; i++) send_burst($urandom_range(0, 14), $urandom_range(1, 48));
    pulse_end(e);
    check_report("random", e);
    sum = 0;
    if (got.size() == 32) for (int c = 0; c < 16; c++) sum += {got[2*c], got[2*c+1]};
    checks++;
    if (sum != 299 || mcnt[15] != 0) begin
      errors++;
      $display("FAIL random_sum: got %0d, expected 299", sum);
    end
  endtask

  task automatic test_restart();
    int e;
    pulse_start();
    for (int i = 0; i < 5; i++) send_burst(2, $urandom_range(1, 20));
    pulse_start();
    for (int i = 0; i < 3; i++) send_burst(2, $urandom_range(1, 20));
    pulse_end(e);
    check_report("restart", e);
  endtask

  task automatic test_sop_at_end();
    int e;
    logic [31:0] r;
    pulse_start();
    send_burst(4, 10);
    got.delete(); got_cyc.delete(); got2.delete();
    r = $urandom();
    ts_din_en = 1'b1;
    ts_din = {r[31:4], 4'd4};
    rate_con_end = 1'b1;
    tick();
    e = cyc;
    rate_con_end = 1'b0;
    mcnt[4]++;
    mmeas = 0;
    for (int i = 0; i < 20; i++) begin
      ts_din = $urandom();
      tick();
    end
    ts_din_en = 1'b0;
    tick();
    send_burst(4, 5);
    check_report("sop_at_end", e);
  endtask

  task automatic test_start_end_together();
    int e;
    got.delete(); got_cyc.delete(); got2.delete();
    rate_con_start = 1'b1;
    rate_con_end = 1'b1;
    tick();
    rate_con_start = 1'b0;
    rate_con_end = 1'b0;
    model_clear();
    mmeas = 1;
    repeat (40) tick();
    checks++;
    if (got.size() != 0) begin
      errors++;
      $display("FAIL start_end_together: got %0d bytes, expected 0", got.size());
    end
    send_burst(6, 5);
    send_burst(6, 7);
    pulse_end(e);
    check_report("window_reopened", e);
  endtask

  task automatic test_saturation();
    int e;
    pulse_start();
    for (int i = 0; i < 300; i++) send_burst(1, 1);
    send_burst(7, 2);
    pulse_end(e);
    check_report("saturation", e);
  endtask

  task automatic test_reset_mid_dump();
    int e;
    pulse_start();
    for (int i = 0; i < 4; i++) send_burst(4, 3);
    pulse_end(e);
    repeat (10) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rate_dout_en !== 1'b0 || rate_dout_en2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dump_en: en=%b en2=%b, expected 0 0", rate_dout_en, rate_dout_en2);
    end
    rst = 1'b1;
    model_clear();
    mmeas = 0;
    repeat (40) tick();
    checks++;
    if (got.size() != 10 || got2.size() != 10) begin
      errors++;
      $display("FAIL reset_mid_dump_count: got %0d/%0d bytes, expected 10/10", got.size(), got2.size());
    end else begin
      checks++;
      if (got[9] !== 8'h04 || got[8] !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid_dump_ch4: got %h%h, expected 0004", got[8], got[9]);
      end
    end
    pulse_end(e);
    repeat (40) tick();
    checks++;
    if (got.size() != 0) begin
      errors++;
      $display("FAIL idle_after_reset: got %0d bytes on end pulse, expected 0", got.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_random();
    test_restart();
    test_sop_at_end();
    test_start_end_together();
    test_saturation();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
